// File: rtl/gb_ppu_pkg.sv
// Shared PPU types and sizes: OAM geometry, the selected-sprite entry and the mode-2 scan states.
package gb_ppu_pkg;

    localparam int OAM_ENTRIES     = 40;
    localparam int MAX_SPRITES     = 10;
    localparam int OAM_SCAN_BYTES  = 2 * OAM_ENTRIES;   // Y and X byte of every entry
    localparam int SCAN_LAST_CYCLE = OAM_SCAN_BYTES + 1; // cycle holding entry 39's X data

    typedef struct packed {
        logic [7:0] x;
        logic [5:0] idx;
        logic [3:0] row;
    } sprite_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } oam_scan_state_t;

    // Scan byte j walks Y,X of each entry: OAM address 4*(j>>1) + (j&1).
    function automatic logic [7:0] oam_byte_addr(input logic [6:0] j);
        return {j[6:1], 1'b0, j[0]};
    endfunction

endpackage

// File: rtl/oam_scan_if.sv
// OAM read port as seen by the mode-2 scanner (master) and the OAM memory (slave).
interface oam_scan_if;
    logic       oam_en;
    logic [7:0] oam_addr;
    logic [7:0] oam_din;

    modport master (output oam_en, output oam_addr, input oam_din);
    modport slave  (input oam_en, input oam_addr, output oam_din);
endinterface

// File: rtl/oam_scan_sprite_buffer.sv
// Selected-sprite register file: one write port, one combinational read port, synchronous clear.
module sprite_buffer
    import gb_ppu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          we,
    input  logic [3:0]    wr_sel,
    input  sprite_entry_t wr_data,
    input  logic [3:0]    rd_sel,
    output sprite_entry_t rd_data
);

    sprite_entry_t entries [MAX_SPRITES];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SPRITES; gi++) begin : gen_entry
            sprite_entry_t entry_q;

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    entry_q <= '0;
                end else if (we && (wr_sel == 4'(gi))) begin
                    entry_q <= wr_data;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    // Indices past the last slot read as an empty entry.
    always_comb begin
        rd_data = '0;
        if (rd_sel < 4'(MAX_SPRITES)) begin
            rd_data = entries[rd_sel];
        end
    end

endmodule

// File: rtl/oam_scan.sv
// PPU mode-2 sprite search: streams OAM Y/X bytes and keeps the first 10 sprites on the scanline.
// Optional OAM_SCAN_HIT_TOTAL_EN adds hit_total, a count of every hitting entry including dropped ones.
module oam_scan
    import gb_ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic        obj_size,
    oam_scan_if.master  oam,
    output logic        busy,
    output logic        done,
    output logic [3:0]  sprite_count,
    input  logic [3:0]  rd_sel,
    output logic [7:0]  rd_x,
    output logic [5:0]  rd_oam_idx,
    output logic [3:0]  rd_row
`ifdef OAM_SCAN_HIT_TOTAL_EN
    ,
    output logic [5:0]  hit_total
`endif
);

    oam_scan_state_t state_q;
    logic [6:0]      cnt_q;       // cycles since start; byte cnt_q-2 is on oam_din
    logic [7:0]      ly_q;
    logic            size_q;
    logic [7:0]      y_q;
    logic            oam_en_q;
    logic [7:0]      oam_addr_q;
    logic            busy_q;
    logic            done_q;
    logic [3:0]      count_q;
`ifdef OAM_SCAN_HIT_TOTAL_EN
    logic [5:0]      hit_total_q;
`endif

    logic            y_cycle;
    logic            x_cycle;
    logic [5:0]      entry_idx;
    logic [8:0]      diff;
    logic            hit;
    logic            wr_en;
    sprite_entry_t   wr_entry;
    sprite_entry_t   rd_entry;

    // Even cycles carry Y data, odd cycles from 3 on carry the matching X data.
    assign y_cycle   = (state_q == SCAN) && !cnt_q[0] && (cnt_q >= 7'd2);
    assign x_cycle   = (state_q == SCAN) &&  cnt_q[0] && (cnt_q >= 7'd3);
    assign entry_idx = 6'((cnt_q - 7'd3) >> 1);

    // Wraps mod 512, so Y=0 and Y>=160 fall outside the window for visible lines.
    assign diff     = {1'b0, ly_q} + 9'd16 - {1'b0, y_q};
    assign hit      = size_q ? (diff < 9'd16) : (diff < 9'd8);
    assign wr_en    = x_cycle && hit && (count_q < 4'(MAX_SPRITES));
    assign wr_entry = '{x: oam.oam_din, idx: entry_idx, row: diff[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ly_q       <= '0;
            size_q     <= 1'b0;
            y_q        <= '0;
            oam_en_q   <= 1'b0;
            oam_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
`ifdef OAM_SCAN_HIT_TOTAL_EN
            hit_total_q <= '0;
`endif
        end else if (start) begin
            state_q    <= SCAN;
            cnt_q      <= 7'd1;
            ly_q       <= ly;
            size_q     <= obj_size;
            y_q        <= '0;
            oam_en_q   <= 1'b1;
            oam_addr_q <= oam_byte_addr(7'd0);
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            count_q    <= '0;
`ifdef OAM_SCAN_HIT_TOTAL_EN
            hit_total_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                SCAN: begin
                    cnt_q <= cnt_q + 7'd1;
                    if (cnt_q < 7'(OAM_SCAN_BYTES)) begin
                        oam_en_q   <= 1'b1;
                        oam_addr_q <= oam_byte_addr(cnt_q);
                    end else begin
                        oam_en_q   <= 1'b0;
                        oam_addr_q <= '0;
                    end
                    if (y_cycle) begin
                        y_q <= oam.oam_din;
                    end
                    if (wr_en) begin
                        count_q <= count_q + 4'd1;
                    end
`ifdef OAM_SCAN_HIT_TOTAL_EN
                    if (x_cycle && hit) begin
                        hit_total_q <= hit_total_q + 6'd1;
                    end
`endif
                    if (cnt_q == 7'(SCAN_LAST_CYCLE)) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sprite_buffer u_sprite_buffer (
        .clk     (clk),
        .reset   (reset),
        .clr     (start),
        .we      (wr_en),
        .wr_sel  (count_q),
        .wr_data (wr_entry),
        .rd_sel  (rd_sel),
        .rd_data (rd_entry)
    );

    assign oam.oam_en   = oam_en_q;
    assign oam.oam_addr = oam_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sprite_count = count_q;
    assign rd_x         = rd_entry.x;
    assign rd_oam_idx   = rd_entry.idx;
    assign rd_row       = rd_entry.row;
`ifdef OAM_SCAN_HIT_TOTAL_EN
    assign hit_total    = hit_total_q;
`endif

endmodule

// File: doc/oam_scan.md
# oam_scan

PPU mode-2 sprite search stage sitting directly downstream of the 160-byte OAM memory. On a `start` pulse it streams the Y/X bytes of all 40 OAM entries through the OAM's single registered read port. It selects, in OAM order, the first 10 sprites that overlap the current scanline and holds them in a small buffer. The sprite pixel fetcher (mode 3) reads that buffer by index.

## Interface
Parameters:
- none (sizes fixed by the package constants below)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse at the beginning of mode 2
- `ly`  in  8  current scanline (0–153)
- `obj_size`  in  1  LCDC bit 2: 0 = 8x8 sprites, 1 = 8x16 sprites
- `oam_en`  out  1  OAM enable
- `oam_addr`  out  8  OAM byte address
- `oam_din`  in  8  OAM `dout` (one-cycle registered read latency)
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse when the scan completes
- `sprite_count`  out  4  number of sprites selected (0–10)
- `rd_sel`  in  4  buffer read index
- `rd_x`  out  8  X byte of the selected buffer entry
- `rd_oam_idx`  out  6  OAM entry number (0–39) of the selected entry
- `rd_row`  out  4  row within the sprite for `ly` (0–15)

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE → SCAN on `start`.
  - SCAN → DONE after the X data of entry 39 is evaluated.
  - DONE → IDLE after one cycle; `done` = 1 only in DONE.
- On `start`:
  - latch `ly` and `obj_size`; all comparisons use the latched values;
  - clear the byte pointer `j` (0–79), `sprite_count`, and all 10 buffer entries to zero.
- `start` while in SCAN or DONE restarts the scan from entry 0. `reset` has priority over `start`.
- Byte addressing: byte `j` maps to `oam_addr` = 4·(j>>1) + (j&1). Entry `i` Y is at 4i; entry `i` X is at 4i+1.
- In the Y data cycle, capture `oam_din` into `y_q`.
- In the X data cycle, compute 9-bit `diff` = {0,ly_q} + 16 − {0,y_q}, modulo 512.
  - Hit when `diff` < 8 (`obj_size` = 0) or `diff` < 16 (`obj_size` = 1).
  - Row = `diff[3:0]`.
- On a hit with `sprite_count` < 10: write {x = `oam_din`, idx = i, row} to entry `sprite_count`, then increment `sprite_count`.
- Hits beyond 10 are dropped, but the scan always runs all 40 entries so its timing is fixed.
- Y = 0 and Y ≥ 160 never hit for `ly` ≤ 143. This follows from the arithmetic; there is no special case.
- X is stored unfiltered; X = 0 and X ≥ 168 still count toward the 10-sprite limit.
- Buffer read is combinational from `rd_sel`. `rd_sel` ≥ 10 returns all zeros.
- `sprite_count` and the buffer hold their contents after DONE until the next `start` or `reset`.
- `oam_we` is not driven by this block; the OAM bus arbiter ties it low during mode 2.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- Cycles 1–80: `oam_en` = 1, `oam_addr` = address of byte j = cycle − 1.
- Data for byte j is valid on `oam_din` in cycle j+2:
  - entry `i` Y data in cycle 2i+2;
  - entry `i` X data in cycle 2i+3;
  - buffer write at the end of cycle 2i+3.
- `busy` = 1 in cycles 1–81. `done` = 1 in cycle 82. The final `sprite_count` is visible from cycle 82.
- Outside cycles 1–80, `oam_en` = 0 and `oam_addr` = 0.
- Reset values: `oam_en` 0, `oam_addr` 0, `busy` 0, `done` 0, `sprite_count` 0, buffer all zero, state IDLE.
- `reset` mid-scan: next cycle is IDLE with everything at reset values; no `done` is produced.

## Configuration
- `OAM_SCAN_HIT_TOTAL_EN` defined:
  - adds output `hit_total` (6 bits, reset 0, cleared on `start`);
  - counts every hitting entry, including those dropped past the 10-sprite limit;
  - final value is valid at `done`.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `gb_ppu_pkg`:
  - `OAM_ENTRIES` = 40
  - `MAX_SPRITES` = 10
  - `sprite_entry_t` packed struct {x[7:0], idx[5:0], row[3:0]}
  - state enum `oam_scan_state_t`
- Sub-module `sprite_buffer`:
  - 10 × `sprite_entry_t` register file;
  - one write port and one combinational read port;
  - synchronous clear;
  - shared later with the fetcher's priority logic.

## Test plan
- Reset: after `reset` → `busy`/`done`/`oam_en` 0, `oam_addr` 0, `sprite_count` 0, `rd_sel` 0 reads all zeros.
- Address sequence: `start` → cycles 1–80 drive `oam_addr` 0, 1, 4, 5, …, 156, 157; `done` pulses only in cycle 82.
- Single sprite: entry 5 Y = 16, X = 8, `obj_size` 0.
  - `ly` 0 → count 1, entry 0 {x 8, idx 5, row 0}.
  - `ly` 7 → row 7.
  - `ly` 8 → count 0.
  - `obj_size` 1, `ly` 15 → row 15.
- Limit: entries 0–11 Y = 20, others Y = 0, `ly` 10 → count 10, idx 0–9 in order, `rd_sel` 10 reads zeros, `hit_total` = 12 (macro on).
- Reset mid-scan: `reset` in cycle 40 → IDLE next cycle, no `done`. A following `start` completes with the correct count.
- Restart: second `start` in cycle 30 → counters cleared, `done` exactly 82 cycles after the second `start`.
